sha1_block_streamer: RTL and testbench

- Sits between the message collector and the SHA-1 round core inside each collision searcher.
- On a start pulse it latches the 512-bit base message and a 32-bit candidate counter.
- It forms the SHA-1-padded input (base words, then counter word, then the 0x80000000 pad word, zero fill and the 64-bit bit length) and streams it one 32-bit W word per cycle to the round core over a valid/ready handshake.
- It emits one or two 512-bit blocks, depending on BASE_WORDS.

---
 rtl/sha1_pkg.sv | 19 +
 rtl/sha1_block_streamer_if.sv | 28 ++
 rtl/sha1_pad_word_gen.sv | 57 +++++
 rtl/sha1_block_streamer.sv | 105 ++++++++++
 tb/tb_sha1_block_streamer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 streaming definitions: word/block geometry, the padding marker word,
// the block streamer FSM state type and a 32-bit byte-reversal helper.
package sha1_pkg;

  localparam int unsigned SHA1_WORD_W      = 32;
  localparam int unsigned SHA1_BLOCK_WORDS = 16;
  localparam logic [SHA1_WORD_W-1:0] SHA1_PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFinish
  } sha1_state_e;

  function automatic logic [SHA1_WORD_W-1:0] sha1_bswap32(input logic [SHA1_WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sha1_block_streamer_if.sv
// W-word stream between the block streamer (master) and the SHA-1 round core (slave).
//   w_valid       : w_data is valid this cycle
//   w_ready       : round core accepts w_data this cycle
//   w_data        : current W word
//   w_index       : word position within the current block (0..15)
//   w_block_first : word 0 of a block (core loads IV or chaining value)
//   w_msg_last    : word 15 of the final block
interface sha1_block_streamer_if;
  import sha1_pkg::*;

  logic                   w_valid;
  logic                   w_ready;
  logic [SHA1_WORD_W-1:0] w_data;
  logic [3:0]             w_index;
  logic                   w_block_first;
  logic                   w_msg_last;

  modport master (
    output w_valid, w_data, w_index, w_block_first, w_msg_last,
    input  w_ready
  );

  modport slave (
    input  w_valid, w_data, w_index, w_block_first, w_msg_last,
    output w_ready
  );

endinterface

// File: rtl/sha1_pad_word_gen.sv
// Combinational SHA-1 padded-message word former.
// Maps a global word position (16*block + index) to: base word, candidate counter,
// pad marker 0x80000000, low 32 bits of the bit length (last word of last block), or 0.
// Optional macro STREAMER_BSWAP_EN: byte-reverse base and counter words only.
//   pos_i     : global word position
//   message_i : latched 512-bit base message, word k at [511-32k -: 32]
//   counter_i : latched candidate counter
//   word_o    : formed W word
module sha1_pad_word_gen
  import sha1_pkg::*;
#(
  parameter int unsigned BASE_WORDS = 12,
  parameter int unsigned NUM_BLOCKS = 1
) (
  input  logic [4:0]                              pos_i,
  input  logic [SHA1_BLOCK_WORDS*SHA1_WORD_W-1:0] message_i,
  input  logic [SHA1_WORD_W-1:0]                  counter_i,
  output logic [SHA1_WORD_W-1:0]                  word_o
);

  localparam logic [4:0] CtrPos = 5'(BASE_WORDS);
  localparam logic [4:0] PadPos = 5'(BASE_WORDS + 1);
  localparam logic [4:0] LenPos = 5'(SHA1_BLOCK_WORDS * NUM_BLOCKS - 1);
  // Total message length in bits: base words plus the counter word.
  localparam logic [SHA1_WORD_W-1:0] LenWord = 32'((BASE_WORDS + 1) * SHA1_WORD_W);

  logic [SHA1_WORD_W-1:0] base_words [SHA1_BLOCK_WORDS];

  for (genvar k = 0; k < SHA1_BLOCK_WORDS; k++) begin : g_split
    assign base_words[k] = message_i[(SHA1_BLOCK_WORDS-1-k)*SHA1_WORD_W +: SHA1_WORD_W];
  end

`ifdef STREAMER_BSWAP_EN
  // Host-loaded words arrive little-endian; pad/length words are already canonical.
  function automatic logic [SHA1_WORD_W-1:0] host_word(input logic [SHA1_WORD_W-1:0] w);
    return sha1_bswap32(w);
  endfunction
`else
  function automatic logic [SHA1_WORD_W-1:0] host_word(input logic [SHA1_WORD_W-1:0] w);
    return w;
  endfunction
`endif

  always_comb begin
    word_o = '0;
    if (pos_i < CtrPos) begin
      word_o = host_word(base_words[pos_i[3:0]]);
    end else if (pos_i == CtrPos) begin
      word_o = host_word(counter_i);
    end else if (pos_i == PadPos) begin
      word_o = SHA1_PAD_WORD;
    end else if (pos_i == LenPos) begin
      word_o = LenWord;
    end
  end

endmodule

// File: rtl/sha1_block_streamer.sv
// SHA-1 block streamer: latches a base message and candidate counter on start and streams
// the padded message (one or two blocks) one W word per cycle over valid/ready.
// Optional macro STREAMER_BSWAP_EN (handled in sha1_pad_word_gen): byte-swap host words.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   start   : request one candidate, honoured only while idle
//   message : 512-bit base message, sampled on accepted start
//   counter : candidate counter, sampled on accepted start
//   w_if    : W-word stream to the round core (master side)
//   busy    : streaming in progress
//   done    : one-cycle pulse after the final beat is accepted
module sha1_block_streamer
  import sha1_pkg::*;
#(
  parameter int unsigned BASE_WORDS = 12
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [SHA1_BLOCK_WORDS*SHA1_WORD_W-1:0] message,
  input  logic [SHA1_WORD_W-1:0]                  counter,
  sha1_block_streamer_if.master                   w_if,
  output logic                                    busy,
  output logic                                    done
);

  localparam int unsigned NUM_BLOCKS = (BASE_WORDS <= 12) ? 1 : 2;
  localparam logic [4:0]  LastBeat   = 5'(SHA1_BLOCK_WORDS * NUM_BLOCKS - 1);

  sha1_state_e                             state_q, state_d;
  logic [4:0]                              beat_q, beat_d;
  logic [SHA1_BLOCK_WORDS*SHA1_WORD_W-1:0] msg_q, msg_d;
  logic [SHA1_WORD_W-1:0]                  ctr_q, ctr_d;
  logic [SHA1_WORD_W-1:0]                  word;
  logic                                    valid;

  sha1_pad_word_gen #(
    .BASE_WORDS(BASE_WORDS),
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_word_gen (
    .pos_i    (beat_q),
    .message_i(msg_q),
    .counter_i(ctr_q),
    .word_o   (word)
  );

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    msg_d   = msg_q;
    ctr_d   = ctr_q;
    valid   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          msg_d   = message;
          ctr_d   = counter;
          beat_d  = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        valid = 1'b1;
        busy  = 1'b1;
        if (w_if.w_ready) begin
          beat_d = beat_q + 5'd1;
          if (beat_q == LastBeat) begin
            state_d = StFinish;
          end
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Data and flags are gated with valid so the idle bus reads all-zero.
  always_comb begin
    w_if.w_valid       = valid;
    w_if.w_data        = valid ? word : '0;
    w_if.w_index       = valid ? beat_q[3:0] : 4'd0;
    w_if.w_block_first = valid && (beat_q[3:0] == 4'd0);
    w_if.w_msg_last    = valid && (beat_q == LastBeat);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
      msg_q   <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      msg_q   <= msg_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: tb/tb_sha1_block_streamer.sv
// Directed scoreboard bench for sha1_block_streamer at BASE_WORDS = 12, 14 and 13.
module tb_sha1_block_streamer;

  logic         clk;
  logic         reset;
  logic [2:0]   start_v;
  logic [511:0] message;
  logic [31:0]  counter;
  logic         w_ready;
  logic [2:0]   busy_v;
  logic [2:0]   done_v;
  int           sel;

  int total = 0;
  int bad   = 0;

  logic [37:0] q[$];

  sha1_block_streamer_if if12 ();
  sha1_block_streamer_if if14 ();
  sha1_block_streamer_if if13 ();

  assign if12.w_ready = w_ready;
  assign if14.w_ready = w_ready;
  assign if13.w_ready = w_ready;

  sha1_block_streamer #(.BASE_WORDS(12)) u_dut12 (
    .clk(clk), .reset(reset), .start(start_v[0]), .message(message), .counter(counter),
    .w_if(if12), .busy(busy_v[0]), .done(done_v[0])
  );
  sha1_block_streamer #(.BASE_WORDS(14)) u_dut14 (
    .clk(clk), .reset(reset), .start(start_v[1]), .message(message), .counter(counter),
    .w_if(if14), .busy(busy_v[1]), .done(done_v[1])
  );
  sha1_block_streamer #(.BASE_WORDS(13)) u_dut13 (
    .clk(clk), .reset(reset), .start(start_v[2]), .message(message), .counter(counter),
    .w_if(if13), .busy(busy_v[2]), .done(done_v[2])
  );

  logic        obs_valid, obs_first, obs_last, obs_busy, obs_done;
  logic [31:0] obs_data;
  logic [3:0]  obs_index;

  always_comb begin
    obs_busy = busy_v[sel];
    obs_done = done_v[sel];
    if (sel == 0) begin
      obs_valid = if12.w_valid; obs_data = if12.w_data; obs_index = if12.w_index;
      obs_first = if12.w_block_first; obs_last = if12.w_msg_last;
    end else if (sel == 1) begin
      obs_valid = if14.w_valid; obs_data = if14.w_data; obs_index = if14.w_index;
      obs_first = if14.w_block_first; obs_last = if14.w_msg_last;
    end else begin
      obs_valid = if13.w_valid; obs_data = if13.w_data; obs_index = if13.w_index;
      obs_first = if13.w_block_first; obs_last = if13.w_msg_last;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference padded word at global position p.
  function automatic logic [31:0] exp_word(input int bw, input int p, input logic [511:0] msg,
                                           input logic [31:0] ctr);
    int          nb;
    logic [31:0] w;
    bit          host;
    nb   = (bw <= 12) ? 1 : 2;
    host = 1'b0;
    if (p < bw) begin
      w = msg[511-32*p -: 32]; host = 1'b1;
    end else if (p == bw) begin
      w = ctr; host = 1'b1;
    end else if (p == bw + 1) begin
      w = 32'h8000_0000;
    end else if (p == 16*nb - 1) begin
      w = (bw + 1) * 32;
    end else begin
      w = 32'h0;
    end
`ifdef STREAMER_BSWAP_EN
    if (host) w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    if (host) w = w;
`endif
    return w;
  endfunction

  // One candidate on DUT `sel`. Negative *_at values disable that event.
  task automatic run_stream(input int bw, input logic [511:0] msg, input logic [31:0] ctr,
                            input int stall_at, input int restart_at, input int reset_at,
                            input bit finish_start);
    int          nbeats, beats, stall_cnt;
    bit          restarted, aborted;
    logic [37:0] e;
    nbeats = (bw <= 12) ? 16 : 32;
    q.delete();
    for (int p = 0; p < nbeats; p++) begin
      q.push_back({exp_word(bw, p, msg, ctr), 4'(p % 16), (p % 16) == 0, p == nbeats - 1});
    end
    @(posedge clk); #1;
    message = msg; counter = ctr; w_ready = 1'b1;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    beats = 0; stall_cnt = 0; restarted = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 200 && beats < nbeats; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("valid_after_start", obs_valid, 1);
        chk("busy_after_start", obs_busy, 1);
      end
      if (obs_valid && w_ready) begin
        e = q.pop_front();
        chk($sformatf("w_data[%0d]", beats), obs_data, e[37:6]);
        chk($sformatf("w_index[%0d]", beats), obs_index, e[5:2]);
        chk($sformatf("flags[%0d]", beats), {obs_first, obs_last}, e[1:0]);
        beats++;
      end else if (obs_valid) begin
        chk("hold_data", obs_data, q[0][37:6]);
        chk("hold_index", obs_index, q[0][5:2]);
      end else begin
        chk("valid_dropped", obs_valid, 1);
      end
      if (beats == nbeats) break;
      @(posedge clk); #1;
      if (beats == reset_at) begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          chk("rst_valid", obs_valid, 0);
          chk("rst_busy", obs_busy, 0);
          chk("rst_done", obs_done, 0);
          @(posedge clk); #1;
        end
        reset = 1'b1; w_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("post_rst_done", obs_done, 0);
          chk("post_rst_valid", obs_valid, 0);
          @(posedge clk); #1;
        end
        aborted = 1'b1;
        break;
      end
      w_ready = !(beats == stall_at && stall_cnt < 3);
      if (!w_ready) stall_cnt++;
      start_v[sel] = (beats == restart_at) && !restarted;
      if (start_v[sel]) begin
        restarted = 1'b1; counter = 32'd9; message = ~msg;
      end
    end
    if (aborted) begin
      q.delete();
      return;
    end
    chk("handshakes", beats, nbeats);
    @(posedge clk); #1;
    if (finish_start) start_v[sel] = 1'b1;
    @(negedge clk);
    chk("done_pulse", obs_done, 1);
    chk("finish_busy", obs_busy, 0);
    chk("finish_valid", obs_valid, 0);
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    @(negedge clk);
    chk("done_single", obs_done, 0);
    chk("idle_busy", obs_busy, 0);
    chk("idle_valid", obs_valid, 0);
  endtask

  initial begin
    logic [511:0] msg;
    reset = 1'b0; start_v = '0; message = '0; counter = '0; w_ready = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d; #1;
      chk($sformatf("reset_outputs_%0d", d),
          {obs_valid, obs_data, obs_index, obs_first, obs_last, obs_busy, obs_done}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // BASE_WORDS=12, words 1..12, start attempted in the done cycle.
    msg = '0;
    for (int k = 0; k < 12; k++) msg[511-32*k -: 32] = k + 1;
    sel = 0;
    run_stream(12, msg, 32'hDEAD_BEEF, -1, -1, -1, 1'b1);

    // Two-block cases.
    for (int k = 0; k < 16; k++) msg[511-32*k -: 32] = $urandom;
    sel = 1;
    run_stream(14, msg, 32'd5, -1, -1, -1, 1'b0);
    sel = 2;
    run_stream(13, msg, $urandom, -1, -1, -1, 1'b0);

    // Backpressure, ignored restart, mid-stream reset, then a clean stream.
    sel = 0;
    run_stream(12, msg, 32'h1234_5678, 7, -1, -1, 1'b0);
    run_stream(12, msg, 32'hDEAD_BEEF, -1, 4, -1, 1'b0);
    run_stream(12, msg, 32'hCAFE_F00D, -1, -1, 9, 1'b0);
    run_stream(12, ~msg, 32'h0BAD_CAFE, -1, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
